// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter and its seven-segment display.
package counter_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Number of hex digits needed to show a value of the given bit width
  function automatic int ceil_nibbles(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_seg7
  import counter_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Table lookup of the glyph for one hex digit
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/counter_updown_disp.sv
// Modulo-MOD up/down counter with prescaled enable, saturating parallel load,
// one-cycle terminal-count pulse and a multiplexed active-low hex display.
module counter_updown_disp
  import counter_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int MOD      = 256,
  parameter  int DIV      = 1,
  parameter  int SCAN_DIV = 4,
  localparam int NDIG     = ceil_nibbles(WIDTH)
)(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic [NDIG-1:0]  oAn,
  output logic [6:0]       oDisplay
);

  localparam int PW = (DIV > 1)      ? $clog2(DIV)      : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1)     ? $clog2(NDIG)     : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MOD - 1);
  // One bit wider so MOD == 2**WIDTH is representable for the load compare
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);

  logic [PW-1:0]     r_pre;
  logic [WIDTH-1:0]  r_q;
  logic              r_tc;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;
  logic [NDIG-1:0]   r_an;
  logic [6:0]        r_seg;

  logic              w_tick;
  logic [WIDTH-1:0]  w_q_load;
  logic [WIDTH-1:0]  w_q_step;
  logic              w_wrap;
  logic [4*NDIG-1:0] w_qpad;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;
  logic [NDIG-1:0]   w_an;

  // A load suppresses the tick for its cycle, so load always beats count
  assign w_tick   = iEn & ~iLoad & (r_pre == PRE_LAST);
  assign w_q_load = ({1'b0, iData} < MOD_EXT) ? iData : Q_MAX;

  // Next count value on a tick and whether that step wraps
  always_comb begin
    w_q_step = r_q;
    w_wrap   = 1'b0;
    if (iUp) begin
      w_wrap   = (r_q == Q_MAX);
      w_q_step = w_wrap ? '0 : r_q + WIDTH'(1);
    end else begin
      w_wrap   = (r_q == '0);
      w_q_step = w_wrap ? Q_MAX : r_q - WIDTH'(1);
    end
  end

  // Prescaler: counts enabled cycles, cleared by load, frozen when disabled
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (iLoad) begin
      r_pre <= '0;
    end else if (iEn) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
    end
  end

  // Count register and terminal-count pulse (high only in the wrap cycle)
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (iLoad) begin
      r_q  <= w_q_load;
      r_tc <= 1'b0;
    end else if (w_tick) begin
      r_q  <= w_q_step;
      r_tc <= w_wrap;
    end else begin
      r_tc <= 1'b0;
    end
  end

  // Scan timer: advance the digit index every SCAN_DIV cycles
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  // Top nibble is zero-extended when WIDTH is not a multiple of 4
  assign w_qpad = (4 * NDIG)'(r_q);
  assign w_nib  = w_qpad[{r_idx, 2'b00} +: 4];
  assign w_an   = ~(NDIG'(1) << r_idx);

  hex_seg7 u_seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Register anode and segments together so they never disagree on a digit
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_an  <= ~NDIG'(1);
      r_seg <= SEG_0;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign oQ       = r_q;
  assign oTC      = r_tc;
  assign oAn      = r_an;
  assign oDisplay = r_seg;

endmodule

// File: tb/tb_counter_updown_disp.sv
// Directed bench for counter_updown_disp using three parameter sets.
module tb_counter_updown_disp;

  logic       clk = 1'b0;
  logic       rst_n, iEn, iUp, iLoad;
  logic [7:0] iData;

  logic [3:0] qa;  logic tca;  logic [0:0] ana;  logic [6:0] da;
  logic [3:0] qb;  logic tcb;  logic [0:0] anb;  logic [6:0] db;
  logic [7:0] qc;  logic tcc;  logic [1:0] anc;  logic [6:0] dc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [1:0] exp_an [7] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
  logic [6:0] exp_d  [7] = '{7'h08, 7'h30, 7'h30, 7'h08, 7'h08, 7'h30, 7'h30};
  int         exp_b  [5] = '{1, 2, 2, 2, 3};

  always #5 clk = ~clk;

  counter_updown_disp #(.WIDTH(4), .MOD(10), .DIV(1), .SCAN_DIV(4)) u_a (
    .CLK(clk), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iData(iData[3:0]),
    .oQ(qa), .oTC(tca), .oAn(ana), .oDisplay(da));

  counter_updown_disp #(.WIDTH(4), .MOD(10), .DIV(3), .SCAN_DIV(4)) u_b (
    .CLK(clk), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iData(iData[3:0]),
    .oQ(qb), .oTC(tcb), .oAn(anb), .oDisplay(db));

  counter_updown_disp #(.WIDTH(8), .MOD(256), .DIV(1), .SCAN_DIV(2)) u_c (
    .CLK(clk), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iData(iData),
    .oQ(qc), .oTC(tcc), .oAn(anc), .oDisplay(dc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; iEn = 1'b0; iUp = 1'b1; iLoad = 1'b0; iData = 8'h00;
    step(1);
    chk("rst_qa", qa, 0);
    chk("rst_tca", tca, 0);
    chk("rst_ana", ana, 0);
    chk("rst_da", da, 7'h40);
    chk("rst_qc", qc, 0);
    chk("rst_anc", anc, 2'b10);
    chk("rst_dc", dc, 7'h40);

    // Up count mod 10 with a tick every cycle
    rst_n = 1'b1; iEn = 1'b1; iUp = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("up_q", qa, i % 10);
      chk("up_tc", tca, (i % 10) == 0);
      chk("up_disp", da, GLY[(i - 1) % 10]);
    end

    // Down count from reset, then a direction change at 7
    rst_n = 1'b0; step(1); rst_n = 1'b1; iUp = 1'b0;
    step(1); chk("dn_q9", qa, 9); chk("dn_tc9", tca, 1);
    step(1); chk("dn_q8", qa, 8); chk("dn_tc8", tca, 0);
    step(1); chk("dn_q7", qa, 7);
    iUp = 1'b1;
    step(1); chk("dir_q8", qa, 8); chk("dir_tc", tca, 0);

    // Reset at 7 with a tick pending
    iUp = 1'b0;
    step(1); chk("pre_rst_q7", qa, 7);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_q", qa, 0); chk("mid_rst_tc", tca, 0);
    chk("mid_rst_an", ana, 0); chk("mid_rst_d", da, 7'h40);
    rst_n = 1'b1;

    // Saturating load coinciding with a tick, then load with enable low
    iLoad = 1'b1; iData = 8'd12; iEn = 1'b1;
    step(1); chk("ld_sat_q", qa, 9); chk("ld_sat_tc", tca, 0);
    iData = 8'd5; iEn = 1'b0;
    step(1); chk("ld5_q", qa, 5);
    iLoad = 1'b0;
    step(2); chk("hold_q", qa, 5);
    iLoad = 1'b1; iData = 8'd9;
    step(1); chk("ld9_q", qa, 9); chk("ld9_tc", tca, 0);
    iLoad = 1'b0; iEn = 1'b1; iUp = 1'b1;
    step(1); chk("ld_wrap_q", qa, 0); chk("ld_wrap_tc", tca, 1);
    step(1); chk("ld_after_q", qa, 1); chk("ld_after_tc", tca, 0);
    iLoad = 1'b1; iData = 8'd0;
    step(1); chk("ld0_q", qa, 0); chk("ld0_tc", tca, 0);
    iLoad = 1'b0;

    // Prescaler DIV=3 with an enable gap mid-period
    rst_n = 1'b0; iEn = 1'b0; step(1); rst_n = 1'b1; iEn = 1'b1; iUp = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("div_q", qb, k / 3);
    end
    iEn = 1'b0;
    step(5); chk("div_hold_q", qb, 1);
    iEn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("div_resume_q", qb, exp_b[k]);
    end

    // Display scan on the two-digit instance
    rst_n = 1'b0; iEn = 1'b0; step(1); rst_n = 1'b1;
    iLoad = 1'b1; iData = 8'h3A;
    step(1);
    chk("scan_q", qc, 8'h3A); chk("scan_an0", anc, 2'b10); chk("scan_d0", dc, 7'h40);
    iLoad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("scan_an", anc, exp_an[k]);
      chk("scan_d", dc, exp_d[k]);
    end

    // Full-range modulus: natural overflow still raises the pulse
    iLoad = 1'b1; iData = 8'hFF;
    step(1); chk("c_ldff_tc", tcc, 0);
    iLoad = 1'b0; iEn = 1'b1; iUp = 1'b1;
    step(1); chk("c_upwrap_q", qc, 8'h00); chk("c_upwrap_tc", tcc, 1);
    iUp = 1'b0;
    step(1); chk("c_dnwrap_q", qc, 8'hFF); chk("c_dnwrap_tc", tcc, 1);
    step(1); chk("c_dn_q", qc, 8'hFE); chk("c_dn_tc", tcc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
